apu_wb_scheduler: RTL and testbench

APU_WB_SCHEDULER -- requirements
Module: apu_wb_scheduler

---
 rtl/apu_wb_scheduler.sv | 120 ++++++++++++
 tb/tb_apu_wb_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apu_wb_scheduler.sv
// apu_wb_scheduler: writeback reservation line for a multi-latency APU.
// Ports: clk/rst; req_* issue + gnt_o/err_o; flush_i; wb_* writeback; hz_* query; cnt_o.
module apu_wb_scheduler #(
    parameter int TAG_W      = 5,
    parameter int WOP        = 6,
    parameter int MAX_LAT    = 8,
    parameter int LAT_ADDSUB = 1,
    parameter int LAT_MULT   = 1,
    parameter int LAT_CAST   = 1,
    parameter int LAT_MAC    = 2,
    parameter int LAT_DIV    = 4,
    parameter int LAT_SQRT   = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_i,
    input  logic [2:0]                        req_class_i,
    input  logic [WOP-1:0]                    req_op_i,
    input  logic [TAG_W-1:0]                  req_tag_i,
    output logic                              gnt_o,
    output logic                              err_o,
    input  logic                              flush_i,
    output logic                              wb_valid_o,
    output logic [TAG_W-1:0]                  wb_tag_o,
    output logic [WOP-1:0]                    wb_op_o,
    output logic [2:0]                        wb_class_o,
    input  logic [TAG_W-1:0]                  hz_tag_i,
    output logic                              hz_o,
    output logic [$clog2(MAX_LAT+2)-1:0]      cnt_o
);

    localparam int CW = $clog2(MAX_LAT + 2);
    localparam int LW = $clog2(MAX_LAT + 1);

    if (LAT_ADDSUB < 1 || LAT_ADDSUB > MAX_LAT ||
        LAT_MULT   < 1 || LAT_MULT   > MAX_LAT ||
        LAT_CAST   < 1 || LAT_CAST   > MAX_LAT ||
        LAT_MAC    < 1 || LAT_MAC    > MAX_LAT ||
        LAT_DIV    < 1 || LAT_DIV    > MAX_LAT ||
        LAT_SQRT   < 1 || LAT_SQRT   > MAX_LAT) begin : g_lat_chk
        $error("apu_wb_scheduler: every LAT_* must lie in 1..MAX_LAT");
    end

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WOP-1:0]   op;
        logic [2:0]       cls;
    } slot_t;

    slot_t slot_q [0:MAX_LAT];

    logic          legal;
    logic [LW-1:0] lat;
    logic [LW-1:0] lat_m1;

    always_comb begin
        legal = 1'b1;
        lat   = LW'(LAT_ADDSUB);
        case (req_class_i)
            3'd0:    lat = LW'(LAT_ADDSUB);
            3'd1:    lat = LW'(LAT_MULT);
            3'd2:    lat = LW'(LAT_CAST);
            3'd3:    lat = LW'(LAT_MAC);
            3'd4:    lat = LW'(LAT_DIV);
            3'd5:    lat = LW'(LAT_SQRT);
            default: legal = 1'b0;
        endcase
    end

    assign lat_m1 = lat - LW'(1);

    // slot[lat] shifts into slot[lat-1] next edge, so it is the one to test
    assign gnt_o = req_i & legal & ~slot_q[lat].valid & ~flush_i & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= MAX_LAT; k++) begin
                slot_q[k].valid <= 1'b0;
            end
            err_o <= 1'b0;
        end else begin
            err_o <= req_i & ~legal;
            for (int k = 0; k < MAX_LAT; k++) begin
                slot_q[k] <= slot_q[k+1];
            end
            slot_q[MAX_LAT] <= '0;
            if (flush_i) begin
                for (int k = 0; k <= MAX_LAT; k++) begin
                    slot_q[k].valid <= 1'b0;
                end
            end else if (gnt_o) begin
                slot_q[lat_m1] <= '{valid: 1'b1, tag: req_tag_i,
                                    op: req_op_i, cls: req_class_i};
            end
        end
    end

    assign wb_valid_o = slot_q[0].valid;
    assign wb_tag_o   = slot_q[0].tag;
    assign wb_op_o    = slot_q[0].op;
    assign wb_class_o = slot_q[0].cls;

    always_comb begin
        hz_o = 1'b0;
        for (int k = 0; k <= MAX_LAT; k++) begin
            if (slot_q[k].valid && slot_q[k].tag == hz_tag_i) begin
                hz_o = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_o = '0;
        for (int k = 0; k <= MAX_LAT; k++) begin
            cnt_o = cnt_o + CW'(slot_q[k].valid);
        end
    end

endmodule

// File: tb/tb_apu_wb_scheduler.sv
// tb_apu_wb_scheduler: directed stimulus with a due-cycle scoreboard.
// A negedge monitor pops expected writebacks and compares wb_* outputs.
module tb_apu_wb_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_i;
    logic [2:0] req_class_i;
    logic [5:0] req_op_i;
    logic [4:0] req_tag_i;
    logic       gnt_o;
    logic       err_o;
    logic       flush_i;
    logic       wb_valid_o;
    logic [4:0] wb_tag_o;
    logic [5:0] wb_op_o;
    logic [2:0] wb_class_o;
    logic [4:0] hz_tag_i;
    logic       hz_o;
    logic [3:0] cnt_o;

    apu_wb_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .req_class_i (req_class_i),
        .req_op_i    (req_op_i),
        .req_tag_i   (req_tag_i),
        .gnt_o       (gnt_o),
        .err_o       (err_o),
        .flush_i     (flush_i),
        .wb_valid_o  (wb_valid_o),
        .wb_tag_o    (wb_tag_o),
        .wb_op_o     (wb_op_o),
        .wb_class_o  (wb_class_o),
        .hz_tag_i    (hz_tag_i),
        .hz_o        (hz_o),
        .cnt_o       (cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [4:0] tag;
        logic [5:0] op;
        logic [2:0] cls;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    int lat_tab [0:5] = '{1, 1, 1, 2, 4, 5};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    endtask

    function automatic void push_exp(input int due, input logic [4:0] tag,
                                     input logic [5:0] op, input logic [2:0] cls);
        exp_t e;
        int   i;
        e.due = due; e.tag = tag; e.op = op; e.cls = cls;
        i = 0;
        while (i < exp_q.size() && exp_q[i].due <= due) i++;
        exp_q.insert(i, e);
    endfunction

    function automatic void drop_after(input int t);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due > t) exp_q.delete(i);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   due;
        if (mon_en) begin
            due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("wb_valid", 32'(wb_valid_o), 32'(due));
            if (due) begin
                e = exp_q.pop_front();
                if (wb_valid_o === 1'b1) begin
                    chk("wb_tag", 32'(wb_tag_o), 32'(e.tag));
                    chk("wb_op", 32'(wb_op_o), 32'(e.op));
                    chk("wb_class", 32'(wb_class_o), 32'(e.cls));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic fl, input logic rq,
                       input logic [2:0] cls, input logic [5:0] op,
                       input logic [4:0] tag, input logic [4:0] hz,
                       input logic exp_gnt);
        rst = r; flush_i = fl; req_i = rq;
        req_class_i = cls; req_op_i = op; req_tag_i = tag; hz_tag_i = hz;
        #2;
        chk("gnt", 32'(gnt_o), 32'(exp_gnt));
        if (exp_gnt) push_exp(cyc + lat_tab[cls], tag, op, cls);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drv(1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 5'd0, 5'd31, 1'b0);
            tick();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t;
        rst = 1'b1; flush_i = 1'b0; req_i = 1'b0;
        req_class_i = '0; req_op_i = '0; req_tag_i = '0; hz_tag_i = '0;
        tick();
        // request during reset must be denied
        drv(1'b1, 1'b0, 1'b1, 3'd0, 6'd1, 5'd1, 5'd0, 1'b0);
        tick();
        mon_en = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 5'd0, 5'd0, 1'b0);
        chk("rst_cnt", 32'(cnt_o), 0);
        chk("rst_hz", 32'(hz_o), 0);
        chk("rst_err", 32'(err_o), 0);
        tick();

        // DIV tag 3: writeback 4 cycles later, cnt=1 meanwhile
        t = cyc;
        drv(1'b0, 1'b0, 1'b1, 3'd4, 6'd5, 5'd3, 5'd31, 1'b1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drv(1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 5'd0, 5'd31, 1'b0);
            chk("div_cnt", 32'(cnt_o), 1);
            tick();
        end
        drv(1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 5'd0, 5'd31, 1'b0);
        chk("div_cnt_end", 32'(cnt_o), 0);
        tick();
        idle(1);

        // MAC then MULT: MULT collides with MAC in slot[1] once
        drv(1'b0, 1'b0, 1'b1, 3'd3, 6'd2, 5'd1, 5'd31, 1'b1);
        tick();
        drv(1'b0, 1'b0, 1'b1, 3'd1, 6'd3, 5'd2, 5'd31, 1'b0);
        tick();
        drv(1'b0, 1'b0, 1'b1, 3'd1, 6'd3, 5'd2, 5'd31, 1'b1);
        tick();
        idle(3);

        // ADDSUB back-to-back, tags 0..5
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 1'b0, 1'b1, 3'd0, 6'(10 + i), 5'(i), 5'd31, 1'b1);
            tick();
        end
        idle(3);

        // SQRT tag 9, hazard query and flush at t+3
        t = cyc;
        drv(1'b0, 1'b0, 1'b1, 3'd5, 6'd7, 5'd9, 5'd31, 1'b1);
        tick();
        drv(1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 5'd0, 5'd4, 1'b0);
        chk("hz_miss", 32'(hz_o), 0);
        tick();
        idle(1);
        drv(1'b0, 1'b1, 1'b1, 3'd0, 6'd1, 5'd2, 5'd9, 1'b0);
        chk("hz_hit", 32'(hz_o), 1);
        drop_after(t + 3);
        tick();
        drv(1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 5'd0, 5'd9, 1'b0);
        chk("flush_cnt", 32'(cnt_o), 0);
        chk("flush_hz", 32'(hz_o), 0);
        tick();
        idle(3);

        // illegal class 7 with a DIV in flight
        drv(1'b0, 1'b0, 1'b1, 3'd4, 6'd4, 5'd6, 5'd31, 1'b1);
        tick();
        drv(1'b0, 1'b0, 1'b1, 3'd7, 6'd8, 5'd1, 5'd31, 1'b0);
        chk("err_pre", 32'(err_o), 0);
        tick();
        drv(1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 5'd0, 5'd31, 1'b0);
        chk("err_set", 32'(err_o), 1);
        chk("err_cnt", 32'(cnt_o), 1);
        tick();
        drv(1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 5'd0, 5'd31, 1'b0);
        chk("err_clr", 32'(err_o), 0);
        tick();
        idle(4);

        // reset mid-flight discards DIV tag 12
        t = cyc;
        drv(1'b0, 1'b0, 1'b1, 3'd4, 6'd1, 5'd12, 5'd31, 1'b1);
        tick();
        idle(1);
        drv(1'b1, 1'b0, 1'b1, 3'd0, 6'd2, 5'd13, 5'd12, 1'b0);
        chk("rst_hz_live", 32'(hz_o), 1);
        drop_after(t + 2);
        tick();
        drv(1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 5'd0, 5'd12, 1'b0);
        chk("rst_mid_cnt", 32'(cnt_o), 0);
        chk("rst_mid_hz", 32'(hz_o), 0);
        tick();
        idle(4);

        // only exact slot collisions deny
        drv(1'b0, 1'b0, 1'b1, 3'd4, 6'd20, 5'd20, 5'd31, 1'b1);
        tick();
        drv(1'b0, 1'b0, 1'b1, 3'd1, 6'd21, 5'd21, 5'd31, 1'b1);
        tick();
        drv(1'b0, 1'b0, 1'b1, 3'd3, 6'd22, 5'd22, 5'd31, 1'b0);
        tick();
        drv(1'b0, 1'b0, 1'b1, 3'd3, 6'd22, 5'd22, 5'd31, 1'b1);
        tick();
        idle(8);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
